// File: rtl/diff_manch_decoder.sv
// diff_manch_decoder: differential Manchester receiver; oversampled mid-bit lock, bit/valid/lock/err outputs.
// Define DIFF_MANCH_DEC_ERRCNT_EN to add a saturating 8-bit err_cnt output.
module diff_manch_decoder #(
  parameter int HB          = 4,
  parameter int TOL         = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
`ifdef DIFF_MANCH_DEC_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       q,
  output logic       q_valid,
  output logic       locked,
  output logic       err
);
  localparam int MAX = 2*HB+TOL+1;
  localparam int CW  = $clog2(MAX+1);
  typedef enum logic {HUNT, DATA} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q, edge_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_sat;
  logic [CW:0] nx;
  logic seen_q, seen_d, q_q, q_d, vld_q, vld_d, lock_q, lock_d, err_q, err_d;
  logic in_b, in_m, viol;
  // nx counts the current cycle too, so an edge gap of g clks compares as g
  assign nx      = (CW+1)'(cnt_q) + (CW+1)'(1);
  assign cnt_sat = (nx >= (CW+1)'(MAX)) ? CW'(MAX) : CW'(nx);
  assign in_b    = nx >= (CW+1)'(HB-TOL) && nx <= (CW+1)'(HB+TOL);
  assign in_m    = nx >= (CW+1)'(2*HB-TOL) && nx <= (CW+1)'(2*HB+TOL);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_sat;
    seen_d  = seen_q;
    q_d     = q_q;
    vld_d   = 1'b0;
    lock_d  = lock_q;
    err_d   = 1'b0;
    viol    = 1'b0;
    if (state_q == HUNT) begin
      if (edge_q) begin
        cnt_d = '0;
        if (in_m) begin
          state_d = DATA;
          lock_d  = 1'b1;
          seen_d  = 1'b0;
        end
      end
    end else if (edge_q) begin
      if (in_b && !seen_q) seen_d = 1'b1;
      else if (in_m) begin
        q_d    = ~seen_q;
        vld_d  = 1'b1;
        cnt_d  = '0;
        seen_d = 1'b0;
      end else viol = 1'b1;
    end else viol = nx == (CW+1)'(MAX);
    if (viol) begin
      err_d   = 1'b1;
      lock_d  = 1'b0;
      state_d = HUNT;
      cnt_d   = '0;
      seen_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
      state_q <= HUNT;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      q_q     <= 1'b0;
      vld_q   <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q  <= sync_q[SYNC_STAGES-1];
      edge_q  <= sync_q[SYNC_STAGES-1] ^ prev_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      q_q     <= q_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end
`ifdef DIFF_MANCH_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else if (err_q && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign err_cnt = err_cnt_q;
`endif
  assign q       = q_q;
  assign q_valid = vld_q;
  assign locked  = lock_q;
  assign err     = err_q;
endmodule

// File: tb/tb_diff_manch_decoder.sv
// tb_diff_manch_decoder: directed, table-driven bench for diff_manch_decoder (HB=4, TOL=1, SYNC_STAGES=2).
module tb_diff_manch_decoder;
  localparam int HB = 4;
  logic clk = 1'b0, rst = 1'b1, d = 1'b0;
  logic q, q_valid, locked, err;
`ifdef DIFF_MANCH_DEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif
  diff_manch_decoder #(.HB(HB), .TOL(1), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .d(d),
`ifdef DIFF_MANCH_DEC_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .q(q),
    .q_valid(q_valid),
    .locked(locked),
    .err(err)
  );
  always #5 clk = ~clk;
  typedef struct { bit b; int s; bit eq; } vec_t;
  vec_t tbl[$];
  int vecs = 0, bad = 0, cyc = 0, n_err = 0, n_ovl = 0;
  bit got[$];
  int t_got[$];
  logic lvl = 1'b0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      if (q_valid) begin
        got.push_back(q);
        t_got.push_back(cyc);
      end
      if (err) n_err++;
      if (q_valid && err) n_ovl++;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic flip();
    lvl = ~lvl;
    d = lvl;
  endtask
  // s shifts the mid-bit transition by s clks
  task automatic send_bit(input bit b, input int s);
    if (!b) flip();
    clks(HB + s);
    flip();
    clks(HB - s);
  endtask
  task automatic add(input bit b, input int s, input bit eq);
    tbl.push_back('{b, s, eq});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int base, ne, lk_drop;
    bit e6[4];
    e6 = '{1'b0, 1'b1, 1'b1, 1'b0};
    add(1,0,1); add(0,0,0); add(1,0,1); add(1,0,1);
    add(0,0,0); add(0,0,0); add(1,0,1); add(0,0,0);
    for (int i = 0; i < 16; i++) add(0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 0, 1);
    add(1,1,1); add(0,1,0); add(1,0,1); add(0,-1,0); add(1,-1,1); add(0,0,0); add(1,0,1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = ~d;
      @(negedge clk);
      chk("rst_outputs", int'({q, q_valid, locked, err}), 0);
    end
    rst = 1'b0;
    lvl = d;
    @(negedge clk);
    chk("post_rst_outputs", int'({q, q_valid, locked, err}), 0);
    clks(20);
    send_bit(1, 0);
    chk("unlocked_after_pre1", locked, 0);
    send_bit(1, 0);
    chk("locked_after_pre2", locked, 1);
    chk("no_valid_preamble", got.size(), 0);
    base = got.size();
    ne = n_err;
    lk_drop = 0;
    foreach (tbl[i]) begin
      send_bit(tbl[i].b, tbl[i].s);
      if (!locked) lk_drop++;
    end
    chk("stream_valid_count", got.size() - base, tbl.size());
    foreach (tbl[i])
      if (base + i < got.size()) chk($sformatf("stream_q[%0d]", i), got[base+i], tbl[i].eq);
    for (int i = 0; i < 7; i++)
      if (base + i + 1 < t_got.size()) chk($sformatf("spacing[%0d]", i), t_got[base+i+1] - t_got[base+i], 8);
    chk("stream_err", n_err - ne, 0);
    chk("stream_lock_drop", lk_drop, 0);
    base = got.size();
    ne = n_err;
    send_bit(1, 0);
    send_bit(1, 2);
    send_bit(1, 0);
    chk("late_edge_err", n_err - ne, 1);
    chk("late_edge_unlock", locked, 0);
    chk("late_edge_valids", got.size() - base, 1);
    send_bit(1, 0);
    chk("late_edge_relock", locked, 1);
    send_bit(0, 0);
    send_bit(1, 0);
    chk("relock_valids", got.size() - base, 3);
    if (got.size() - base == 3) begin
      chk("relock_q0", got[base], 1);
      chk("relock_q1", got[base+1], 0);
      chk("relock_q2", got[base+2], 1);
    end
    base = got.size();
    ne = n_err;
    clks(12);
    chk("idle_err", n_err - ne, 1);
    chk("idle_unlock", locked, 0);
    chk("idle_no_valid", got.size() - base, 0);
    send_bit(1, 0);
    send_bit(1, 0);
    if (lvl != 1'b1) send_bit(1, 0);
    chk("pre_rst_locked", locked, 1);
    base = got.size();
    flip();
    clks(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clks(HB - 3);
    flip();
    clks(HB);
    chk("midbit_rst_unlocked", locked, 0);
    chk("midbit_rst_no_valid", got.size() - base, 0);
    send_bit(1, 0);
    chk("midbit_rst_relock", locked, 1);
    ne = n_err;
    for (int i = 0; i < 4; i++) send_bit(e6[i], 0);
    chk("resume_valids", got.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < got.size()) chk($sformatf("resume_q[%0d]", i), got[base+i], e6[i]);
    chk("resume_err", n_err - ne, 0);
    chk("valid_err_overlap", n_ovl, 0);
`ifdef DIFF_MANCH_DEC_ERRCNT_EN
    repeat (300) begin
      send_bit(1, 0);
      send_bit(1, 0);
      clks(12);
    end
    chk("err_cnt_sat", err_cnt, 255);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("err_cnt_rst", err_cnt, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
